byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer.sv | 84 ++++++++
 tb/tb_byte_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Packs bytes popped from an upstream FIFO into 32-bit words (first byte in lane 0),
// emitting partial words on an explicit flush or after an idle timeout.
module byte_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [2:0]  word_bytes,
  output logic        word_valid,
  input  logic        word_ready
);

  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [3:0][7:0] asm_r;
  logic [2:0]      cnt;
  logic            infl;
  logic [7:0]      idle;

  logic tmo, drain_req, emit_ready, out_free, xfer, rd_req;

  always_comb begin
    tmo        = (idle == 8'(FLUSH_TIMEOUT));
    // A full word is emitted regardless, so flush/timeout only matter below four bytes.
    drain_req  = (state == FILL) && (cnt != 3'd4) &&
                 ((flush && ((cnt != 3'd0) || infl)) || (tmo && (cnt != 3'd0)));
    out_free   = !word_valid || word_ready;
    emit_ready = (cnt == 3'd4) || ((state == DRAIN) && !infl && (cnt != 3'd0));
    xfer       = emit_ready && out_free;
    rd_req     = (state == FILL) && !drain_req && (({1'b0, cnt} + {3'b000, infl}) < 4'd4);
    fifo_rd_en = rst && rd_req && !fifo_empty;

    state_nxt = state;
    case (state)
      FILL: begin
        if (drain_req)                        state_nxt = DRAIN;
        else if ((cnt == 3'd4) && !out_free)  state_nxt = HOLD;
      end
      HOLD:    if (xfer) state_nxt = FILL;
      DRAIN:   if (xfer || ((cnt == 3'd0) && !infl)) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      asm_r      <= '0;
      cnt        <= '0;
      infl       <= 1'b0;
      idle       <= '0;
      word_out   <= '0;
      word_bytes <= '0;
      word_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      infl  <= fifo_rd_en;
      // Transfer never coincides with a capture: cnt==4 implies no pop in flight,
      // and a drain transfer waits for infl to clear.
      if (xfer) begin
        word_out   <= asm_r;
        word_bytes <= cnt;
        word_valid <= 1'b1;
        asm_r      <= '0;
        cnt        <= '0;
      end else begin
        if (word_valid && word_ready) word_valid <= 1'b0;
        if (infl) begin
          asm_r[cnt[1:0]] <= fifo_dout;
          cnt             <= 3'(cnt + 3'd1);
        end
      end
      if (infl || (cnt == 3'd0) || (state != FILL) || xfer) idle <= '0;
      else if (!tmo)                                         idle <= 8'(idle + 8'd1);
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: behavioural FIFO feeding the DUT and a
// scoreboard of expected words compared at each downstream acceptance.
module tb_byte_packer;

  logic        clk, rst, fifo_empty, fifo_rd_en, flush, word_valid, word_ready;
  logic [7:0]  fifo_dout;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;

  byte_packer #(.FLUSH_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .word_out(word_out),
    .word_bytes(word_bytes), .word_valid(word_valid), .word_ready(word_ready)
  );

  typedef struct { logic [31:0] w; logic [2:0] b; } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, vcyc = 0, bad_pop = 0, rdc = 0, got = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [2:0] b);
    exp_t e;
    e.w = w;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + 8'(i)));
    fifo_empty = 1'b0;
  endtask

  // One clock: sample at the falling edge, model the FIFO pop after the rising edge.
  task automatic tick();
    logic rd, acc;
    exp_t e;
    @(negedge clk);
    rd  = fifo_rd_en;
    acc = word_valid && word_ready;
    if (word_valid) vcyc++;
    if (rd) rdc++;
    if (rd && fifo_empty) bad_pop++;
    if (acc) begin
      got++;
      chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_word", 64'(word_out), 64'(e.w));
        chk("sb_bytes", 64'(word_bytes), 64'(e.b));
      end
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      pops++;
      fifo_dout = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_got(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (got < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(got >= target), 64'd1);
  endtask

  initial begin
    int t0, vs, rs, ps;
    rst        = 1'b0;
    fifo_empty = 1'b0;
    fifo_dout  = 8'hEE;
    flush      = 1'b0;
    word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_word", 64'(word_out), 64'd0);
    chk("rst_bytes", 64'(word_bytes), 64'd0);
    fifo_empty = 1'b1;
    rst = 1'b1;

    // Four bytes, always-ready sink
    pops = 0; vcyc = 0;
    expect_word(32'h04030201, 3'd4);
    load(8'h01, 4);
    wait_got("s1_wait", 1, 40);
    run(5);
    chk("s1_pops", 64'(pops), 64'd4);
    chk("s1_valid_cycles", 64'(vcyc), 64'd1);

    // Eight bytes with a stalled sink
    word_ready = 1'b0;
    pops = 0;
    expect_word(32'h13121110, 3'd4);
    expect_word(32'h17161514, 3'd4);
    load(8'h10, 8);
    run(30);
    chk("s2_pops", 64'(pops), 64'd8);
    chk("s2_valid", 64'(word_valid), 64'd1);
    chk("s2_word", 64'(word_out), 64'h13121110);
    run(5);
    chk("s2_hold_word", 64'(word_out), 64'h13121110);
    chk("s2_hold_bytes", 64'(word_bytes), 64'd4);
    chk("s2_hold_pops", 64'(pops), 64'd8);
    word_ready = 1'b1;
    tick();
    chk("s2_next_valid", 64'(word_valid), 64'd1);
    chk("s2_next_word", 64'(word_out), 64'h17161514);
    wait_got("s2_wait", 3, 10);

    // Partial word emitted by idle timeout
    expect_word(32'h00000B0A, 3'd2);
    t0 = cyc;
    load(8'h0A, 2);
    wait_got("s3_wait", 4, 60);
    chk("s3_latency", 64'((cyc - t0) >= 19 && (cyc - t0) <= 24), 64'd1);

    // Flush with nothing buffered is a no-op
    vs = vcyc;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(20);
    chk("s4_noop_flush", 64'(vcyc - vs), 64'd0);

    // Flush with one byte captured and a second in flight
    expect_word(32'h00006655, 3'd2);
    load(8'h55, 1);
    run(2);
    load(8'h66, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_got("s4_wait", 5, 10);

    // Empty FIFO for 50 cycles
    vs = vcyc; rs = rdc; ps = bad_pop;
    run(50);
    chk("s5_rd_en", 64'(rdc - rs), 64'd0);
    chk("s5_bad_pop", 64'(bad_pop - ps), 64'd0);
    chk("s5_valid", 64'(vcyc - vs), 64'd0);

    // Reset mid-word with a pop in flight
    load(8'hA1, 4);
    run(4);
    rst = 1'b0;
    #1;
    chk("s6_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("s6_valid", 64'(word_valid), 64'd0);
    chk("s6_word", 64'(word_out), 64'd0);
    chk("s6_bytes", 64'(word_bytes), 64'd0);
    run(2);
    rst = 1'b1;
    run(25);
    chk("s6_no_stray", 64'(got), 64'd5);
    expect_word(32'h24232221, 3'd4);
    load(8'h21, 4);
    wait_got("s6_wait", 6, 40);

    run(3);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("total_words", 64'(got), 64'd6);
    chk("no_pop_when_empty", 64'(bad_pop), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
